// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore control FSM for the multi-cycle RV32I datapath (CTRL_ILLEGAL_TRAP_EN traps unknown opcodes).
// Latency: selects/enables decoded combinationally from the state register; lw 5, sw/R/I/jal 4, jalr 5, branch/lui 3 cycles.
// Backpressure: none, the FSM advances one state per clock; enables are forced low while rst is high.
module multi_cycle_controller #(
    parameter int SUPPORT_BNE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALRPC   = 4'd12,
        LUI      = 4'd13,
        HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t TRAP_STATE = HALT;
`else
    localparam state_t TRAP_STATE = FETCH;
`endif

    state_t state_q;
    state_t state_d;
    logic   bne_en;
    logic   taken;

    assign bne_en  = (SUPPORT_BNE != 0);
    assign taken   = ((funct3 == 3'b000) & zero) | (bne_en & (funct3 == 3'b001) & ~zero);
    assign state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = TRAP_STATE;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            JALR:     state_d = JALRPC;
            JALRPC:   state_d = ALUWB;
            LUI:      state_d = FETCH;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = taken;
            end
            JAL, JALRPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset lands the FSM in FETCH at once; its enables must stay quiet until release.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE: imm_src = 3'b001;
            OP_BR:    imm_src = 3'b010;
            OP_JAL:   imm_src = 3'b011;
            OP_LUI:   imm_src = 3'b100;
            default:  imm_src = 3'b000;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if ((state_q == DECODE) && (state_d == HALT)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q & ~rst;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
